// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding (common with the transmitter) and byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] UART_ST_IDLE      = 2'd0;
  localparam logic [1:0] UART_ST_ISSUE     = 2'd1;
  localparam logic [1:0] UART_ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] UART_ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = UART_ST_IDLE,
    S_ISSUE     = UART_ST_ISSUE,
    S_WAIT_BUSY = UART_ST_WAIT_BUSY,
    S_WAIT_DONE = UART_ST_WAIT_DONE
  } arb_state_e;

  // Index width that stays at least 1 bit for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and transmitter-side signals of the UART TX arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DATA_W
) ();

  localparam int GID_W = idx_w(N_REQ);

  logic [N_REQ-1:0]        i_REQ_VALID;
  logic [N_REQ*DATA_W-1:0] i_REQ_DATA;
  logic [N_REQ-1:0]        o_REQ_READY;
  logic                    o_TX_ENABLE;
  logic [DATA_W-1:0]       o_TX_DATA;
  logic                    i_TX_BUSY;
  logic [GID_W-1:0]        o_GRANT_ID;
  logic                    o_ACTIVE;
  logic                    o_TIMEOUT_ERR;
  logic                    i_CLR_ERR;

  modport slave (
    input  i_REQ_VALID, i_REQ_DATA, i_TX_BUSY, i_CLR_ERR,
    output o_REQ_READY, o_TX_ENABLE, o_TX_DATA, o_GRANT_ID, o_ACTIVE, o_TIMEOUT_ERR
  );

  modport master (
    output i_REQ_VALID, i_REQ_DATA, i_TX_BUSY, i_CLR_ERR,
    input  o_REQ_READY, o_TX_ENABLE, o_TX_DATA, o_GRANT_ID, o_ACTIVE, o_TIMEOUT_ERR
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  function automatic logic [IDX_W-1:0] wrap(input int base, input int off);
    return IDX_W'((base + off) % N_REQ);
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[wrap(int'(ptr), i)]) begin
        found                  = 1'b1;
        idx                    = wrap(int'(ptr), i);
        grant[wrap(int'(ptr), i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers with round-robin grants,
// a single-cycle registered enable and a busy-rise watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = UART_DATA_W,
  parameter int BUSY_TIMEOUT = 7
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w(BUSY_TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  gid_q;
  logic [IDX_W-1:0]  grant_idx;
  logic [N_REQ-1:0]  grant_oh;
  logic [N_REQ-1:0]  ready;
  logic              any_req;
  logic              take;
  logic              timeout;
  logic [DATA_W-1:0] data_q;
  logic              en_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    if (int'(cur) >= N_REQ - 1) return '0;
    return cur + 1'b1;
  endfunction

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (bus.i_REQ_VALID),
    .ptr   (ptr_q),
    .grant (grant_oh),
    .idx   (grant_idx),
    .found (any_req)
  );

  always_comb begin
    state_d = state_q;
    ready   = '0;
    take    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          ready   = grant_oh;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.i_TX_BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.i_TX_BUSY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= take;
      if (take) begin
        data_q <= bus.i_REQ_DATA[int'(grant_idx)*DATA_W +: DATA_W];
        gid_q  <= grant_idx;
        ptr_q  <= next_idx(grant_idx);
      end
      // Counter is rearmed on every issue and frozen once the limit is reached.
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT_BUSY && !bus.i_TX_BUSY && !timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end else if (bus.i_CLR_ERR) begin
        err_q <= 1'b0;
      end
    end
  end

  // Ready is withheld while reset is asserted even though the state already reads IDLE.
  assign bus.o_REQ_READY   = i_RESET ? '0 : ready;
  assign bus.o_TX_ENABLE   = en_q;
  assign bus.o_TX_DATA     = data_q;
  assign bus.o_GRANT_ID    = gid_q;
  assign bus.o_ACTIVE      = (state_q != S_IDLE);
  assign bus.o_TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural 10-bit UART transmitter and a frame/grant scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(7)) dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transmitter: samples enable, raises busy two edges later, sends start, 8 data LSB-first, stop.
  logic          tx_busy, tx_line, tx_pend;
  logic          tx_dead = 1'b0;
  logic [DW-1:0] tx_hold;
  logic [9:0]    tx_sh;
  int            tx_bit;
  assign bus.i_TX_BUSY = tx_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_pend <= 1'b0;
      tx_bit  <= 0;
      tx_sh   <= '0;
      tx_hold <= '0;
    end else begin
      if (tx_pend) begin
        tx_pend <= 1'b0;
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, tx_hold, 1'b0};
        tx_line <= 1'b0;
        tx_bit  <= 1;
      end else if (tx_busy) begin
        if (tx_bit == 10) begin
          tx_busy <= 1'b0;
          tx_line <= 1'b1;
        end else begin
          tx_line <= tx_sh[tx_bit];
          tx_bit  <= tx_bit + 1;
        end
      end
      if (bus.o_TX_ENABLE && !tx_busy && !tx_pend && !tx_dead) begin
        tx_pend <= 1'b1;
        tx_hold <= bus.o_TX_DATA;
      end
    end
  end

  // Passive monitor: handshakes and received serial frames.
  logic [9:0] rx_fr;
  int         rx_n = 0;
  logic [9:0] rx_q[$];
  int         acc_q[$];
  int         hs_cnt[N] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (rst) begin
      rx_n <= 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (bus.i_REQ_VALID[k] && bus.o_REQ_READY[k]) begin
          hs_cnt[k] <= hs_cnt[k] + 1;
          acc_q.push_back(k);
        end
      if (tx_busy === 1'b1) begin
        if (rx_n < 10) rx_fr[rx_n] <= tx_line;
        rx_n <= rx_n + 1;
      end else if (rx_n > 0) begin
        rx_q.push_back(rx_fr);
        rx_n <= 0;
      end
    end
  end

  // Scoreboard expectations and per-requester source queues.
  logic [7:0] exp_q[$];
  int         exp_id_q[$];
  logic [7:0] src_q[N][$];

  task automatic drive_reqs(input int budget, output bit ok);
    logic [N-1:0] hs;
    int cyc;
    cyc = 0;
    ok  = 1'b1;
    for (int k = 0; k < N; k++)
      if (src_q[k].size() > 0) begin
        bus.i_REQ_DATA[k*DW +: DW] = src_q[k].pop_front();
        bus.i_REQ_VALID[k] = 1'b1;
      end
    forever begin
      @(negedge clk);
      hs = bus.i_REQ_VALID & bus.o_REQ_READY;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (hs[k]) begin
          if (src_q[k].size() > 0) bus.i_REQ_DATA[k*DW +: DW] = src_q[k].pop_front();
          else bus.i_REQ_VALID[k] = 1'b0;
        end
      if (bus.i_REQ_VALID == '0 && !bus.o_ACTIVE) break;
      cyc++;
      if (cyc > budget) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.o_REQ_READY[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_CLR_ERR   = 1'b0;
    bus.i_REQ_VALID = '1;
    bus.i_REQ_DATA  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.o_REQ_READY !== 4'b0000) begin miscompares++; $display("FAIL rst_ready got %b want 0000", bus.o_REQ_READY); end
    vectors++; if (bus.o_TX_ENABLE !== 1'b0) begin miscompares++; $display("FAIL rst_enable got %b want 0", bus.o_TX_ENABLE); end
    vectors++; if (bus.o_TX_DATA !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h want 00", bus.o_TX_DATA); end
    vectors++; if (bus.o_GRANT_ID !== 2'd0) begin miscompares++; $display("FAIL rst_gid got %0d want 0", bus.o_GRANT_ID); end
    vectors++; if (bus.o_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL rst_active got %b want 0", bus.o_ACTIVE); end
    vectors++; if (bus.o_TIMEOUT_ERR !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", bus.o_TIMEOUT_ERR); end
    bus.i_REQ_VALID = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (bus.o_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL rst_idle got %b want 0", bus.o_ACTIVE); end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [7:0] e; int eid; logic [9:0] fr; int aid;
    src_q[0].push_back(8'h10); src_q[0].push_back(8'h14);
    src_q[1].push_back(8'h11); src_q[2].push_back(8'h12); src_q[3].push_back(8'h13);
    exp_q.push_back(8'h10); exp_id_q.push_back(0);
    exp_q.push_back(8'h11); exp_id_q.push_back(1);
    exp_q.push_back(8'h12); exp_id_q.push_back(2);
    exp_q.push_back(8'h13); exp_id_q.push_back(3);
    exp_q.push_back(8'h14); exp_id_q.push_back(0);
    drive_reqs(300, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL fair_done got %b want 1", ok); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); eid = exp_id_q.pop_front();
      if (rx_q.size() > 0) fr = rx_q.pop_front(); else fr = 10'bx;
      if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
      vectors++; if (aid !== eid) begin miscompares++; $display("FAIL fair_grant got %0d want %0d", aid, eid); end
      vectors++; if (fr !== {1'b1, e, 1'b0}) begin miscompares++; $display("FAIL fair_frame got %b want %b", fr, {1'b1, e, 1'b0}); end
    end
  endtask

  task automatic test_rotation();
    bit ok;
    logic [7:0] e; int eid; logic [9:0] fr; int aid;
    src_q[1].push_back(8'h21);
    exp_q.push_back(8'h21); exp_id_q.push_back(1);
    drive_reqs(100, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rot_first got %b want 1", ok); end
    src_q[0].push_back(8'h30); src_q[3].push_back(8'h33);
    exp_q.push_back(8'h33); exp_id_q.push_back(3);
    exp_q.push_back(8'h30); exp_id_q.push_back(0);
    drive_reqs(100, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rot_pair got %b want 1", ok); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); eid = exp_id_q.pop_front();
      if (rx_q.size() > 0) fr = rx_q.pop_front(); else fr = 10'bx;
      if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
      vectors++; if (aid !== eid) begin miscompares++; $display("FAIL rot_grant got %0d want %0d", aid, eid); end
      vectors++; if (fr !== {1'b1, e, 1'b0}) begin miscompares++; $display("FAIL rot_frame got %b want %b", fr, {1'b1, e, 1'b0}); end
    end
  endtask

  task automatic test_single();
    bit ok; int h0; int c;
    logic [9:0] fr; int aid;
    h0 = hs_cnt[2];
    bus.i_REQ_DATA[2*DW +: DW] = 8'hA5;
    bus.i_REQ_VALID[2] = 1'b1;
    exp_q.push_back(8'hA5); exp_id_q.push_back(2);
    wait_ready(2, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b want 1", ok); end
    @(posedge clk);
    #1;
    bus.i_REQ_VALID[2] = 1'b0;
    vectors++; if (bus.o_TX_ENABLE !== 1'b1) begin miscompares++; $display("FAIL single_en got %b want 1", bus.o_TX_ENABLE); end
    vectors++; if (bus.o_GRANT_ID !== 2'd2) begin miscompares++; $display("FAIL single_gid got %0d want 2", bus.o_GRANT_ID); end
    vectors++; if (bus.o_TX_DATA !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", bus.o_TX_DATA); end
    @(posedge clk);
    #1;
    vectors++; if (bus.o_TX_ENABLE !== 1'b0) begin miscompares++; $display("FAIL single_en_pulse got %b want 0", bus.o_TX_ENABLE); end
    c = 0;
    while (tx_busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    while (tx_busy !== 1'b0 && c < 40) begin @(negedge clk); c++; end
    vectors++; if (c >= 40) begin miscompares++; $display("FAIL single_busy_wait got %0d cycles want <40", c); end
    vectors++; if (bus.o_ACTIVE !== 1'b1) begin miscompares++; $display("FAIL single_active_hold got %b want 1", bus.o_ACTIVE); end
    @(posedge clk);
    #1;
    vectors++; if (bus.o_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL single_active_drop got %b want 0", bus.o_ACTIVE); end
    vectors++; if (hs_cnt[2] - h0 !== 1) begin miscompares++; $display("FAIL single_ready_count got %0d want 1", hs_cnt[2] - h0); end
    if (rx_q.size() > 0) fr = rx_q.pop_front(); else fr = 10'bx;
    if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
    vectors++; if (fr !== {1'b1, exp_q.pop_front(), 1'b0}) begin miscompares++; $display("FAIL single_frame got %b want 1101001010", fr); end
    vectors++; if (aid !== exp_id_q.pop_front()) begin miscompares++; $display("FAIL single_grant got %0d want 2", aid); end
  endtask

  task automatic test_held_data();
    bit ok; int c;
    logic [9:0] fr; int aid;
    bus.i_REQ_DATA[1*DW +: DW] = 8'h3C;
    bus.i_REQ_VALID[1] = 1'b1;
    exp_q.push_back(8'h3C); exp_id_q.push_back(1);
    wait_ready(1, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL held_ready got %b want 1", ok); end
    @(posedge clk);
    #1;
    bus.i_REQ_DATA[1*DW +: DW] = 8'hFF;
    bus.i_REQ_VALID[1] = 1'b0;
    c = 0;
    while (bus.o_ACTIVE === 1'b1 && c < 40) begin
      vectors++; if (bus.o_TX_DATA !== 8'h3C) begin miscompares++; $display("FAIL held_data cycle %0d got %h want 3c", c, bus.o_TX_DATA); end
      @(posedge clk);
      #1;
      c++;
    end
    vectors++; if (c >= 40) begin miscompares++; $display("FAIL held_idle got busy after %0d cycles want idle", c); end
    if (rx_q.size() > 0) fr = rx_q.pop_front(); else fr = 10'bx;
    if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
    vectors++; if (fr !== {1'b1, exp_q.pop_front(), 1'b0}) begin miscompares++; $display("FAIL held_frame got %b want 1001111000", fr); end
    vectors++; if (aid !== exp_id_q.pop_front()) begin miscompares++; $display("FAIL held_grant got %0d want 1", aid); end
  endtask

  task automatic test_timeout();
    bit ok; int aid;
    logic [7:0] e; int eid; logic [9:0] fr;
    tx_dead = 1'b1;
    bus.i_REQ_DATA[0 +: DW] = 8'h42;
    bus.i_REQ_VALID[0] = 1'b1;
    wait_ready(0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL to_ready got %b want 1", ok); end
    @(posedge clk);
    #1;
    bus.i_REQ_VALID[0] = 1'b0;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    vectors++; if (bus.o_TIMEOUT_ERR !== 1'b0) begin miscompares++; $display("FAIL to_early got %b want 0", bus.o_TIMEOUT_ERR); end
    vectors++; if (bus.o_ACTIVE !== 1'b1) begin miscompares++; $display("FAIL to_wait_active got %b want 1", bus.o_ACTIVE); end
    @(posedge clk);
    #1;
    vectors++; if (bus.o_TIMEOUT_ERR !== 1'b1) begin miscompares++; $display("FAIL to_set got %b want 1", bus.o_TIMEOUT_ERR); end
    vectors++; if (bus.o_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL to_idle got %b want 0", bus.o_ACTIVE); end
    if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
    vectors++; if (aid !== 0) begin miscompares++; $display("FAIL to_grant got %0d want 0", aid); end
    tx_dead = 1'b0;
    src_q[2].push_back(8'h5A);
    exp_q.push_back(8'h5A); exp_id_q.push_back(2);
    drive_reqs(100, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL to_next_done got %b want 1", ok); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); eid = exp_id_q.pop_front();
      if (rx_q.size() > 0) fr = rx_q.pop_front(); else fr = 10'bx;
      if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
      vectors++; if (aid !== eid) begin miscompares++; $display("FAIL to_next_grant got %0d want %0d", aid, eid); end
      vectors++; if (fr !== {1'b1, e, 1'b0}) begin miscompares++; $display("FAIL to_next_frame got %b want %b", fr, {1'b1, e, 1'b0}); end
    end
    vectors++; if (bus.o_TIMEOUT_ERR !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %b want 1", bus.o_TIMEOUT_ERR); end
    bus.i_CLR_ERR = 1'b1;
    @(posedge clk);
    #1;
    bus.i_CLR_ERR = 1'b0;
    vectors++; if (bus.o_TIMEOUT_ERR !== 1'b0) begin miscompares++; $display("FAIL to_clear got %b want 0", bus.o_TIMEOUT_ERR); end
  endtask

  task automatic test_reset_midframe();
    bit ok; int c; int h1; int aid;
    bus.i_REQ_DATA[3*DW +: DW] = 8'h77;
    bus.i_REQ_VALID[3] = 1'b1;
    wait_ready(3, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", ok); end
    @(posedge clk);
    #1;
    bus.i_REQ_VALID[3] = 1'b0;
    c = 0;
    while (tx_busy !== 1'b1 && c < 20) begin @(posedge clk); c++; end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.o_GRANT_ID !== 2'd3 || bus.o_ACTIVE !== 1'b1) begin miscompares++; $display("FAIL mid_inflight got gid %0d active %b want 3 1", bus.o_GRANT_ID, bus.o_ACTIVE); end
    h1 = hs_cnt[3];
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.o_ACTIVE !== 1'b0) begin miscompares++; $display("FAIL mid_active got %b want 0", bus.o_ACTIVE); end
    vectors++; if (bus.o_GRANT_ID !== 2'd0) begin miscompares++; $display("FAIL mid_gid got %0d want 0", bus.o_GRANT_ID); end
    vectors++; if (bus.o_TX_DATA !== 8'h00) begin miscompares++; $display("FAIL mid_data got %h want 00", bus.o_TX_DATA); end
    vectors++; if (bus.o_TX_ENABLE !== 1'b0) begin miscompares++; $display("FAIL mid_enable got %b want 0", bus.o_TX_ENABLE); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    vectors++; if (hs_cnt[3] !== h1) begin miscompares++; $display("FAIL mid_no_reready got %0d want %0d", hs_cnt[3], h1); end
    vectors++; if (rx_q.size() !== 0) begin miscompares++; $display("FAIL mid_dropped got %0d frames want 0", rx_q.size()); end
    if (acc_q.size() > 0) aid = acc_q.pop_front(); else aid = -1;
    vectors++; if (aid !== 3) begin miscompares++; $display("FAIL mid_grant got %0d want 3", aid); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_rotation();
    test_single();
    test_held_data();
    test_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no end of test want finish before 400us");
    $fatal(1, "watchdog expired");
  end

endmodule
